// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the multi-cycle sequencer and memory.
// mem_req (with mem_we) is held high until a cycle where mem_ready=1 completes it.
// mem_ready is only meaningful while mem_req is high.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and counts retirements.
module multicycle_ctrl (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [5:0]               Op,
    input  logic [5:0]               Funct,
    input  logic                     Zero,
    multicycle_ctrl_if.master        mem,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     RegWrite,
    output logic                     RegDst,
    output logic                     ALUsrc,
    output logic [1:0]               PCSrc,
    output logic [1:0]               WBSel,
    output logic [1:0]               ExtOp,
    output logic [1:0]               WBH,
    output logic [3:0]               ALUOp,
    output logic                     illegal,
    output logic [31:0]              instr_cnt,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic        retire;
    logic        req, we;

    // Instruction class and per-instruction datapath controls
    logic       legal, is_load, is_store, is_beq, is_jr, is_jalr;
    logic       dec_rd, dec_as;
    logic [1:0] dec_ext, dec_wbh;
    logic [3:0] dec_alu;

    always_comb begin
        legal    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_beq   = 1'b0;
        is_jr    = 1'b0;
        is_jalr  = 1'b0;
        dec_rd   = 1'b0;
        dec_as   = 1'b0;
        dec_ext  = 2'b00;
        dec_wbh  = 2'b00;
        dec_alu  = 4'b0000;
        case (Op)
            6'h00: begin
                dec_rd = 1'b1;
                case (Funct)
                    6'h20, 6'h21: legal = 1'b1;
                    6'h22, 6'h23: begin legal = 1'b1; dec_alu = 4'b0001; end
                    6'h00:        begin legal = 1'b1; dec_alu = 4'b0011; end
                    6'h08:        begin legal = 1'b1; is_jr   = 1'b1;    end
                    6'h09:        begin legal = 1'b1; is_jalr = 1'b1;    end
                    default:      legal = 1'b0;
                endcase
            end
            6'h0D: begin legal = 1'b1; dec_as = 1'b1; dec_alu = 4'b0010; end
            6'h0F: begin legal = 1'b1; dec_as = 1'b1; dec_ext = 2'b10;   end
            6'h08: begin legal = 1'b1; dec_as = 1'b1; dec_ext = 2'b01;   end
            6'h23, 6'h21, 6'h20: begin
                legal   = 1'b1;
                is_load = 1'b1;
                dec_as  = 1'b1;
                dec_ext = 2'b01;
                dec_wbh = (Op == 6'h21) ? 2'b10 : (Op == 6'h20) ? 2'b01 : 2'b00;
            end
            6'h2B, 6'h29, 6'h28: begin
                legal    = 1'b1;
                is_store = 1'b1;
                dec_as   = 1'b1;
                dec_ext  = 2'b01;
                dec_wbh  = (Op == 6'h29) ? 2'b10 : (Op == 6'h28) ? 2'b01 : 2'b00;
            end
            6'h04: begin legal = 1'b1; is_beq = 1'b1; dec_ext = 2'b01; dec_alu = 4'b0001; end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUsrc   = 1'b0;
        PCSrc    = 2'b00;
        WBSel    = 2'b00;
        ExtOp    = 2'b00;
        WBH      = 2'b00;
        ALUOp    = 4'b0000;
        illegal  = 1'b0;
        // Datapath selects are held steady from EXEC through WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            RegDst = dec_rd;
            ALUsrc = dec_as;
            ExtOp  = dec_ext;
            WBH    = dec_wbh;
            ALUOp  = dec_alu;
        end
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                req = 1'b1;
                if (mem.mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    PCSrc   = 2'b01;
                    PCWrite = Zero;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jalr) begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                req = 1'b1;
                we  = is_store;
                if (mem.mem_ready) begin
                    retire  = is_store;
                    state_d = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                WBSel    = is_load ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else if (retire) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign instr_cnt   = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions plus
// hand-written wait-state, reset-abort and counter-wrap sequences.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset_n;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        irwrite, pcwrite, regwrite, regdst, alusrc, illegal;
  logic [1:0]  pcsrc, wbsel, extop, wbh;
  logic [3:0]  aluop;
  logic [31:0] instr_cnt;
  logic [2:0]  state_dbg;

  multicycle_ctrl_if mif ();

  multicycle_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Op        (op),
    .Funct     (funct),
    .Zero      (zero),
    .mem       (mif),
    .IRWrite   (irwrite),
    .PCWrite   (pcwrite),
    .RegWrite  (regwrite),
    .RegDst    (regdst),
    .ALUsrc    (alusrc),
    .PCSrc     (pcsrc),
    .WBSel     (wbsel),
    .ExtOp     (extop),
    .WBH       (wbh),
    .ALUOp     (aluop),
    .illegal   (illegal),
    .instr_cnt (instr_cnt),
    .state_dbg (state_dbg)
  );

  // observed vector: {state, req, we, irw, pcw, rw, rd, as, pcs, wbs, ext, wbh, alu, ill}
  logic [22:0] obs;
  assign obs = {state_dbg, mif.mem_req, mif.mem_we, irwrite, pcwrite, regwrite, regdst,
                alusrc, pcsrc, wbsel, extop, wbh, aluop, illegal};

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  function automatic void check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endfunction

  function automatic logic [19:0] mk(input logic req, input logic we, input logic irw,
                                     input logic pcw, input logic rw, input logic rd,
                                     input logic as_i, input logic [1:0] pcs,
                                     input logic [1:0] wbs, input logic [1:0] ext,
                                     input logic [1:0] wbh_i, input logic [3:0] alu,
                                     input logic ill);
    return {req, we, irw, pcw, rw, rd, as_i, pcs, wbs, ext, wbh_i, alu, ill};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          n;
    logic        has_mem;
    logic        retire;
    logic [19:0] v [5];
  } vec_t;

  vec_t vecs[$];
  logic [19:0] f_ok, d_ok, d_ill;

  task automatic add_vec(input string name, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int n, input logic hm, input logic ret,
                         input logic [19:0] d, input logic [19:0] e, input logic [19:0] m,
                         input logic [19:0] w);
    vec_t t;
    t.name = name; t.op = o; t.funct = f; t.zero = z; t.n = n; t.has_mem = hm; t.retire = ret;
    t.v[0] = f_ok; t.v[1] = d; t.v[2] = e;
    t.v[3] = hm ? m : w;
    t.v[4] = w;
    vecs.push_back(t);
  endtask

  function automatic logic [2:0] st_of(input int k, input logic hm);
    case (k)
      0: return 3'd1;
      1: return 3'd2;
      2: return 3'd3;
      3: return hm ? 3'd4 : 3'd5;
      default: return 3'd5;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic rdy, input string tag);
    logic [22:0] e;
    mif.mem_ready = rdy;
    @(negedge clk);
    n_checks += 0;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, {9'd0, obs}, {9'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t t;
    logic rdy;
    t = vecs[i];
    op = t.op; funct = t.funct; zero = t.zero;
    for (int k = 0; k < t.n; k++) exp_q.push_back({st_of(k, t.has_mem), t.v[k]});
    for (int k = 0; k < t.n; k++) begin
      rdy = (k == 0 || (t.has_mem && k == 3)) ? 1'b1 : 1'($urandom_range(0, 1));
      step(rdy, t.name);
    end
    if (t.retire) exp_cnt = exp_cnt + 32'd1;
    check({t.name, "_cnt"}, instr_cnt, exp_cnt);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mif.mem_ready = 1'b1;
    op = 6'h00; funct = 6'h21; zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_obs", {9'd0, obs}, 32'd0);
    check("reset_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("init_obs", {9'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_cnt = 32'd0;
  endtask

  // ---------------- main sequence ----------------
  logic [19:0] e_lw, m_lw, w_lw, e_sw, m_sw;

  initial begin
    reset_n = 1'b0;
    mif.mem_ready = 1'b0;
    op = 6'h00; funct = 6'h00; zero = 1'b0;

    f_ok  = mk(1,0,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,0);
    d_ok  = 20'd0;
    d_ill = mk(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,4'd0,1);
    e_lw  = mk(0,0,0,0,0,0,1,2'd0,2'd0,2'd1,2'd0,4'd0,0);
    m_lw  = mk(1,0,0,0,0,0,1,2'd0,2'd0,2'd1,2'd0,4'd0,0);
    w_lw  = mk(0,0,0,0,1,0,1,2'd0,2'd1,2'd1,2'd0,4'd0,0);
    e_sw  = e_lw;
    m_sw  = mk(1,1,0,0,0,0,1,2'd0,2'd0,2'd1,2'd0,4'd0,0);

    //       name     op     funct  z  n  mem ret  decode exec / mem / wb
    add_vec("addu", 6'h00, 6'h21, 0, 4, 0, 1, d_ok, mk(0,0,0,0,0,1,0,0,0,0,0,4'd0,0), 20'd0,
            mk(0,0,0,0,1,1,0,0,0,0,0,4'd0,0));                                        // 0
    add_vec("add",  6'h00, 6'h20, 1, 4, 0, 1, d_ok, mk(0,0,0,0,0,1,0,0,0,0,0,4'd0,0), 20'd0,
            mk(0,0,0,0,1,1,0,0,0,0,0,4'd0,0));                                        // 1
    add_vec("sub",  6'h00, 6'h22, 0, 4, 0, 1, d_ok, mk(0,0,0,0,0,1,0,0,0,0,0,4'd1,0), 20'd0,
            mk(0,0,0,0,1,1,0,0,0,0,0,4'd1,0));                                        // 2
    add_vec("sll",  6'h00, 6'h00, 0, 4, 0, 1, d_ok, mk(0,0,0,0,0,1,0,0,0,0,0,4'd3,0), 20'd0,
            mk(0,0,0,0,1,1,0,0,0,0,0,4'd3,0));                                        // 3
    add_vec("ori",  6'h0D, 6'h00, 0, 4, 0, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,0,0,4'd2,0), 20'd0,
            mk(0,0,0,0,1,0,1,0,0,0,0,4'd2,0));                                        // 4
    add_vec("lui",  6'h0F, 6'h00, 0, 4, 0, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,2,0,4'd0,0), 20'd0,
            mk(0,0,0,0,1,0,1,0,0,2,0,4'd0,0));                                        // 5
    add_vec("addi", 6'h08, 6'h00, 0, 4, 0, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,1,0,4'd0,0), 20'd0,
            mk(0,0,0,0,1,0,1,0,0,1,0,4'd0,0));                                        // 6
    add_vec("lw",   6'h23, 6'h00, 0, 5, 1, 1, d_ok, e_lw, m_lw, w_lw);                 // 7
    add_vec("lh",   6'h21, 6'h00, 0, 5, 1, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,1,2,4'd0,0),
            mk(1,0,0,0,0,0,1,0,0,1,2,4'd0,0), mk(0,0,0,0,1,0,1,0,1,1,2,4'd0,0));       // 8
    add_vec("lb",   6'h20, 6'h00, 0, 5, 1, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,1,1,4'd0,0),
            mk(1,0,0,0,0,0,1,0,0,1,1,4'd0,0), mk(0,0,0,0,1,0,1,0,1,1,1,4'd0,0));       // 9
    add_vec("sw",   6'h2B, 6'h00, 0, 4, 1, 1, d_ok, e_sw, m_sw, 20'd0);                // 10
    add_vec("sh",   6'h29, 6'h00, 0, 4, 1, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,1,2,4'd0,0),
            mk(1,1,0,0,0,0,1,0,0,1,2,4'd0,0), 20'd0);                                  // 11
    add_vec("sb",   6'h28, 6'h00, 0, 4, 1, 1, d_ok, mk(0,0,0,0,0,0,1,0,0,1,1,4'd0,0),
            mk(1,1,0,0,0,0,1,0,0,1,1,4'd0,0), 20'd0);                                  // 12
    add_vec("beq_z1", 6'h04, 6'h00, 1, 3, 0, 1, d_ok, mk(0,0,0,1,0,0,0,1,0,1,0,4'd1,0),
            20'd0, 20'd0);                                                             // 13
    add_vec("beq_z0", 6'h04, 6'h00, 0, 3, 0, 1, d_ok, mk(0,0,0,0,0,0,0,1,0,1,0,4'd1,0),
            20'd0, 20'd0);                                                             // 14
    add_vec("jr",   6'h00, 6'h08, 0, 3, 0, 1, d_ok, mk(0,0,0,1,0,1,0,2,0,0,0,4'd0,0),
            20'd0, 20'd0);                                                             // 15
    add_vec("jalr", 6'h00, 6'h09, 0, 4, 0, 1, d_ok, mk(0,0,0,1,0,1,0,2,0,0,0,4'd0,0),
            20'd0, mk(0,0,0,0,1,1,0,0,2,0,0,4'd0,0));                                  // 16
    add_vec("ill_op",    6'h3F, 6'h00, 0, 2, 0, 0, d_ill, 20'd0, 20'd0, 20'd0);        // 17
    add_vec("ill_funct", 6'h00, 6'h3F, 0, 2, 0, 0, d_ill, 20'd0, 20'd0, 20'd0);        // 18

    // addu straight out of reset
    do_reset();
    run_vec(0);
    check("first_addu_cnt", instr_cnt, 32'd1);

    foreach (vecs[i]) run_vec(i);
    repeat (20) run_vec(int'($urandom_range(0, vecs.size() - 1)));

    // lw: 2 fetch waits, 3 memory waits, 10 cycles end to end
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    repeat (2) exp_q.push_back({3'd1, mk(1,0,0,0,0,0,0,0,0,0,0,4'd0,0)});
    exp_q.push_back({3'd1, f_ok});
    exp_q.push_back({3'd2, d_ok});
    exp_q.push_back({3'd3, e_lw});
    repeat (4) exp_q.push_back({3'd4, m_lw});
    exp_q.push_back({3'd5, w_lw});
    step(0, "lw_wait_f"); step(0, "lw_wait_f"); step(1, "lw_f");
    step(1'($urandom_range(0, 1)), "lw_d");
    step(1'($urandom_range(0, 1)), "lw_e");
    step(0, "lw_wait_m"); step(0, "lw_wait_m"); step(0, "lw_wait_m");
    step(1, "lw_m");
    step(1'($urandom_range(0, 1)), "lw_wb");
    exp_cnt = exp_cnt + 32'd1;
    check("lw_wait_cnt", instr_cnt, exp_cnt);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    check("lw_back_fetch", {29'd0, state_dbg}, 32'd1);
    @(posedge clk); #1;

    // sb, beq taken, beq not taken: three retirements
    do_reset();
    run_vec(12); run_vec(13); run_vec(14);
    check("sb_beq_cnt", instr_cnt, 32'd3);

    // reset during a sw memory wait
    run_vec(1);
    op = 6'h2B; funct = 6'h00; zero = 1'b0;
    exp_q.push_back({3'd1, f_ok});
    exp_q.push_back({3'd2, d_ok});
    exp_q.push_back({3'd3, e_sw});
    exp_q.push_back({3'd4, m_sw & ~20'h00000 & 20'hFFFFF});
    step(1, "abort_f"); step(0, "abort_d"); step(0, "abort_e"); step(0, "abort_m");
    #2;
    check("abort_pre_req", {30'd0, mif.mem_req, mif.mem_we}, 32'd3);
    check("abort_pre_cnt", instr_cnt, 32'd4);
    reset_n = 1'b0;
    #1;
    check("abort_req_we", {30'd0, mif.mem_req, mif.mem_we}, 32'd0);
    check("abort_obs", {9'd0, obs}, 32'd0);
    check("abort_cnt", instr_cnt, 32'd0);
    do_reset();

    // counter wrap from all-ones
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    check("wrap_preload", instr_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    run_vec(0);
    check("wrap_zero", instr_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS-subset datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives the per-state datapath strobes. It handshakes with a shared instruction/data memory port that may insert wait states, and it counts retired instructions. It sits beside the register file, ALU and PC/IR registers, in place of a purely combinational decoder.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- Op  in  6  opcode from the IR; stable from DECODE onward.
- Funct  in  6  funct field from the IR.
- Zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory port completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write qualifier for mem_req (stores only).
- IRWrite, PCWrite, RegWrite  out  1 each  write strobes.
- RegDst, ALUsrc  out  1 each  rd/rt select; immediate/rt select for B.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 rs register.
- WBSel  out  2  00 ALU, 01 memory data, 10 PC (link).
- ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 lui-shift.
- WBH  out  2  10 halfword, 01 byte, 00 word.
- ALUOp  out  4  0000 add, 0001 sub, 0010 or, 0011 sll.
- illegal  out  1  one-cycle pulse for an unrecognised instruction.
- instr_cnt  out  32  retired-instruction count.

## Operation
- Supported instructions: add, addu, sub, subu, sll, jr, jalr (R-type, Op=0); ori, lui, addi, lw, lh, lb, sw, sh, sb, beq.
- The state register encodes INIT, FETCH, DECODE, EXEC, MEM, WB.
- INIT is the reset state, with all outputs 0. It moves to FETCH unconditionally on the next edge.
- FETCH: mem_req=1 and mem_we=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=00, then DECODE.
- DECODE: no strobes asserted.
  - An unrecognised Op/Funct pulses illegal=1 and goes to FETCH; the instruction is treated as a NOP and not counted.
  - Any recognised instruction goes to EXEC.
- EXEC: RegDst, ALUsrc, ExtOp, ALUOp and WBH are driven per instruction and are also held through MEM and WB.
  - beq: PCSrc=01, PCWrite=Zero, ALUOp=sub, then FETCH.
  - jr: PCSrc=10, PCWrite=1, then FETCH.
  - jalr: PCSrc=10, PCWrite=1, then WB.
  - Loads and stores go to MEM.
  - All other instructions go to WB.
- MEM: mem_req=1; mem_we=1 for sw/sh/sb.
  - Stays in MEM while mem_ready=0.
  - On mem_ready=1: stores go to FETCH; loads go to WB.
- WB: RegWrite=1, then FETCH.
  - WBSel=01 for loads, 10 for jalr, 00 otherwise.
  - RegDst=1 for R-type (jalr links to rd); 0 otherwise.
- Retirement: instr_cnt increments by 1 on the edge leaving the instruction's final state (WB, store MEM with mem_ready, or EXEC for beq/jr). It wraps from 0xFFFFFFFF to 0.
- Strobes are Moore outputs of state plus the IR fields. Only PCWrite in EXEC (uses Zero) and IRWrite/PCWrite in FETCH (use mem_ready) are combinational on inputs.

## Timing
- Reset values: state=INIT, all outputs 0, instr_cnt=0.
- reset_n low mid-instruction aborts it immediately. Outputs go to 0 asynchronously, with no partial write, and the count is not updated.
- Latency with zero memory wait: beq/jr 3 cycles; R-type/ori/lui/addi/jalr/stores 4 cycles; loads 5 cycles. Each memory wait cycle adds 1.
- mem_req rises in the first cycle of FETCH/MEM. It stays high until the cycle mem_ready=1 and drops the next cycle unless the next state requests again.
- mem_ready outside FETCH/MEM is ignored.
- A beq with Zero=0 still retires; PC keeps the PC+4 value written in FETCH.

## Test plan
- Reset release, mem_ready tied 1, addu: INIT→F→D→E→WB, mem_req high 1 cycle, RegWrite high in cycle 4, instr_cnt=1.
- lw with 2 wait cycles in FETCH and 3 in MEM: 10 cycles total, WBSel=01, ExtOp=01, WBH=00 in WB, mem_we never 1.
- sb then beq: sb gives mem_we=1, WBH=01, no RegWrite. beq with Zero=1 gives PCWrite=1, PCSrc=01; beq with Zero=0 gives PCWrite=0. Both retire, instr_cnt=3.
- jalr: EXEC PCSrc=10, PCWrite=1; WB RegDst=1, WBSel=10, RegWrite=1.
- Op=0x3F: illegal pulses in DECODE, back to FETCH, instr_cnt unchanged, no write strobes.
- reset_n dropped during a MEM wait of sw: mem_req/mem_we go to 0 immediately; instr_cnt preloaded by 0xFFFFFFFF retires then wraps to 0 after a clean run.
